// File: rtl/sp_minmax_reduce_if.sv
// sp_minmax_reduce_if
// Handshake/result bundle between the custom-instruction front end (master)
// and the single-precision min/max reduction controller (slave).
//   start/func3/length : request, sampled by the block only while idle
//   in_valid/in_data   : element stream, accepted when in_ready is high
//   busy/done          : activity indicator and one-cycle completion pulse
//   result/result_idx  : reduced binary32 value and its 0-based position
//   flag_invalid       : sticky signalling-NaN indicator for the reduction
interface sp_minmax_reduce_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [2:0]       func3;
  logic [LEN_W-1:0] length;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [31:0]      result;
  logic [LEN_W-1:0] result_idx;
  logic             flag_invalid;

  modport master (
    output start, func3, length, in_valid, in_data,
    input  in_ready, busy, done, result, result_idx, flag_invalid
  );

  modport slave (
    input  start, func3, length, in_valid, in_data,
    output in_ready, busy, done, result, result_idx, flag_invalid
  );
endinterface

// File: rtl/sp_minmax_reduce.sv
// sp_minmax_reduce
// Folds a stream of `length` binary32 elements into a running min (func3=000)
// or max (func3=001), one element per cycle, and reports the winning value,
// its index and a sticky signalling-NaN flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - sp_minmax_reduce_if.slave (request, element stream, results)
// Build option:
//   SP_MINMAX_REDUCE_IDX_EN - when defined the winning index is tracked and
//   driven on result_idx; otherwise result_idx is tied to zero.
module sp_minmax_reduce #(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  sp_minmax_reduce_if.slave bus
);

  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {IDLE, FIRST, ACCUM, FINISH} state_t;

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt, final_val;
  logic [LEN_W-1:0] cnt, cnt_inc, len_q;
  logic [2:0]       func_q;
  logic             flag_acc, flag_nxt;
  logic             hs, last, b_win, take_b, supported;
  logic             in_ready_c, busy_c, done_c;
  logic [31:0]      result_q;
  logic             flag_q;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // Decides whether element b replaces accumulator a. Ties keep a so the
  // lowest index wins; NaNs never displace a number.
  function automatic logic b_wins(input logic [31:0] a, input logic [31:0] b,
                                  input logic is_max);
    logic b_lt_a, b_gt_a, win;
    b_lt_a = 1'b0;
    b_gt_a = 1'b0;
    if (a[31] != b[31]) begin
      b_lt_a = b[31];
      b_gt_a = a[31];
    end else if (a[31]) begin
      b_lt_a = b[30:0] > a[30:0];
      b_gt_a = b[30:0] < a[30:0];
    end else begin
      b_lt_a = b[30:0] < a[30:0];
      b_gt_a = b[30:0] > a[30:0];
    end
    if (is_nan(b))      win = 1'b0;
    else if (is_nan(a)) win = 1'b1;
    else                win = is_max ? b_gt_a : b_lt_a;
    return win;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.length == '0) ? FINISH : FIRST;
      FIRST:   if (hs)        state_nxt = last ? FINISH : ACCUM;
      ACCUM:   if (hs && last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control outputs ----
  always_comb begin
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      FIRST:   begin in_ready_c = 1'b1; busy_c = 1'b1; end
      ACCUM:   begin in_ready_c = 1'b1; busy_c = 1'b1; end
      FINISH:  begin busy_c = 1'b1; done_c = 1'b1; end
      default: ;
    endcase
  end

  // ---- compare datapath ----
  assign hs        = bus.in_valid & in_ready_c;
  assign cnt_inc   = cnt + LEN_W'(1);
  assign last      = (cnt_inc == len_q);
  assign supported = (func_q == 3'b000) || (func_q == 3'b001);
  assign b_win     = (state == ACCUM) && b_wins(acc, bus.in_data, func_q[0]);
  assign take_b    = (state == FIRST) || b_win;
  assign acc_nxt   = take_b ? bus.in_data : acc;
  assign flag_nxt  = flag_acc | is_snan(bus.in_data);
  assign final_val = !supported      ? 32'd0 :
                     is_nan(acc_nxt) ? QNAN  : acc_nxt;

`ifdef SP_MINMAX_REDUCE_IDX_EN
  logic [LEN_W-1:0] idx, idx_nxt, result_idx_q;
  assign idx_nxt = take_b ? cnt : idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      result_idx_q <= '0;
    end else if (state == IDLE && bus.start) begin
      idx          <= '0;
      result_idx_q <= '0;
    end else if (hs) begin
      idx <= idx_nxt;
      if (last) result_idx_q <= supported ? idx_nxt : '0;
    end
  end

  assign bus.result_idx = result_idx_q;
`else
  assign bus.result_idx = '0;
`endif

  // ---- accumulator and result registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= QNAN;
      cnt      <= '0;
      len_q    <= '0;
      func_q   <= 3'b000;
      flag_acc <= 1'b0;
      result_q <= 32'd0;
      flag_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc      <= QNAN;
      cnt      <= '0;
      len_q    <= bus.length;
      func_q   <= bus.func3;
      flag_acc <= 1'b0;
      flag_q   <= 1'b0;
      // An empty reduction completes straight away with the canonical NaN.
      if (bus.length == '0)
        result_q <= (bus.func3[2:1] == 2'b00) ? QNAN : 32'd0;
    end else if (hs) begin
      acc      <= acc_nxt;
      cnt      <= cnt_inc;
      flag_acc <= flag_nxt;
      if (last) begin
        result_q <= final_val;
        flag_q   <= flag_nxt;
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.result       = result_q;
  assign bus.flag_invalid = flag_q;

endmodule

// File: tb/tb_sp_minmax_reduce.sv
module tb_sp_minmax_reduce;

  localparam int LEN_W = 16;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef struct {
    logic [31:0]      res;
    logic [LEN_W-1:0] idx;
    logic             flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  sp_minmax_reduce_if #(.LEN_W(LEN_W)) bus ();

  sp_minmax_reduce #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic f_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 0);
  endfunction

  // Monotonic integer key for IEEE ordering (-0 sorts below +0).
  function automatic logic [31:0] f_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] d[$]);
    exp_t        e;
    logic [31:0] best;
    int          bi;
    logic        flg;
    e.res = (f <= 3'd1) ? QNAN : 32'd0;
    e.idx = '0;
    e.flg = 1'b0;
    if (d.size() == 0) return e;
    best = d[0];
    bi   = 0;
    flg  = f_nan(d[0]) && !d[0][22];
    for (int i = 1; i < d.size(); i++) begin
      if (f_nan(d[i]) && !d[i][22]) flg = 1'b1;
      if (f_nan(d[i])) continue;
      if (f_nan(best) ||
          (f == 3'd1 ? f_key(d[i]) > f_key(best) : f_key(d[i]) < f_key(best))) begin
        best = d[i];
        bi   = i;
      end
    end
    e.flg = flg;
    if (f <= 3'd1) begin
      e.res = f_nan(best) ? QNAN : best;
      e.idx = LEN_W'(bi);
    end
`ifndef SP_MINMAX_REDUCE_IDX_EN
    e.idx = '0;
`endif
    return e;
  endfunction

  // Scoreboard side: every done pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("result", bus.result, mon_e.res);
        check_val("result_idx", 32'(bus.result_idx), 32'(mon_e.idx));
        check_val("flag_invalid", 32'(bus.flag_invalid), 32'(mon_e.flg));
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Feeds one element; returns once it has been accepted (bounded).
  task automatic send_elem(input logic [31:0] v, input bit poke);
    bit rdy;
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    if (poke) begin
      bus.start  = 1'b1;
      bus.length = '0;
    end
    t = 0;
    forever begin
      rdy = bus.in_ready;
      step();
      if (rdy) break;
      if (++t > 50) begin
        check_val("handshake_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic reduce(input logic [2:0] f, input logic [31:0] d[$],
                        input bit gaps, input bit poke);
    sb.push_back(model(f, d));
    bus.start  = 1'b1;
    bus.func3  = f;
    bus.length = LEN_W'(d.size());
    step();
    bus.start = 1'b0;
    if (d.size() == 0) begin
      check_val("done_len0", 32'(bus.done), 32'd1);
    end else begin
      check_val("busy", 32'(bus.busy), 32'd1);
      foreach (d[i]) begin
        if (gaps && (i % 2 == 1)) step();
        send_elem(d[i], poke && (i == 0));
      end
      check_val("done_latency", 32'(bus.done), 32'd1);
    end
    step();
    check_val("done_pulse_width", 32'(bus.done), 32'd0);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_elem();
    logic [31:0] specials [8];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7fc0_0000, 32'h7f80_0001,
                 32'h0000_0001, 32'h8000_0003, 32'h7f80_0000, 32'hff80_0000};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
    return $urandom();
  endfunction

  initial begin
    logic [31:0] d[$];
    bus.start    = 1'b0;
    bus.func3    = 3'b000;
    bus.length   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    step();
    check_val("idle_done", 32'(bus.done), 32'd0);
    check_val("idle_flag", 32'(bus.flag_invalid), 32'd0);

    d = '{32'h3f80_0000, 32'hc000_0000, 32'h40b0_0000, 32'h40b0_0000};
    reduce(3'b001, d, 1'b0, 1'b0);
    d = '{32'h0000_0000, 32'h8000_0000};
    reduce(3'b000, d, 1'b0, 1'b0);
    d = '{32'h7fc0_0000, 32'h4000_0000, 32'h7f80_0001};
    reduce(3'b001, d, 1'b1, 1'b0);
    d = '{32'h7fc0_0001, 32'hffc0_0000};
    reduce(3'b000, d, 1'b0, 1'b0);
    d = {};
    reduce(3'b000, d, 1'b0, 1'b0);
    d = '{32'h3f80_0000, 32'h3f00_0000, 32'h4000_0000};
    reduce(3'b000, d, 1'b0, 1'b1);
    d = '{32'h7f80_0001};
    reduce(3'b000, d, 1'b0, 1'b0);
    d = '{32'h0000_0003, 32'h0000_0001, 32'h8000_0002};
    reduce(3'b001, d, 1'b1, 1'b0);
    d = '{32'h4000_0000, 32'h3f80_0000};
    reduce(3'b011, d, 1'b0, 1'b0);

    // Abort a 5-element reduction after two elements.
    bus.start  = 1'b1;
    bus.func3  = 3'b001;
    bus.length = LEN_W'(5);
    step();
    bus.start = 1'b0;
    send_elem(32'h4120_0000, 1'b0);
    send_elem(32'h4130_0000, 1'b0);
    rst = 1'b1;
    #1;
    check_val("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_done", 32'(bus.done), 32'd0);
    check_val("abort_result", bus.result, 32'd0);
    check_val("abort_idx", 32'(bus.result_idx), 32'd0);
    check_val("abort_flag", 32'(bus.flag_invalid), 32'd0);
    step();
    rst = 1'b0;
    step();
    d = '{32'hbf80_0000, 32'hc040_0000, 32'hc000_0000};
    reduce(3'b001, d, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      d = {};
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) d.push_back(rand_elem());
      reduce(3'($urandom_range(0, 1)), d, n[0], 1'b0);
    end

    repeat (5) step();
    check_val("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
